ramp_adc_ctrl: RTL and testbench
================================

Name: ramp_adc_ctrl

Overview:
- Sequencer for the single-slope (ramp) conversion built around the analog comparator.
- Discharges the ramp, releases it, and counts clock cycles until the comparator output falls; the count is the conversion result.
- Handles out-of-range inputs (timeout/underflow), single-shot and continuous modes, and a valid/ready result handshake toward the host.
- Sits between the comparator model/pin and the result consumer.

Parameters:
- CNT_W, 16: width of the conversion counter and of the result.
- MAX_COUNT, 1000: ramp timeout in cycles; must be less than 2^CNT_W.
- SETTLE_CYCLES, 4: cycles the ramp is held in discharge before each conversion; must be at least 1.
- SYNC_STAGES, 2: comparator synchronizer depth; must be at least 2.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle request to begin a conversion; ignored unless in IDLE.
- continuous, in, 1: level; when 1, a new conversion begins immediately after each capture.
- abort, in, 1: returns to IDLE from any state; no result is produced.
- comp, in, 1: asynchronous comparator output; 1 = ramp below input.
- ramp_reset, out, 1: 1 = ramp capacitor discharged/held.
- busy, out, 1: 1 in any state other than IDLE.
- result, out, CNT_W: last conversion count.
- status, out, 2: 00 = OK, 01 = OVERFLOW (timeout), 10 = UNDERFLOW.
- result_valid, out, 1: result/status available.
- result_ready, in, 1: consumer accepts result.
- overrun, out, 1: one-cycle pulse when an unaccepted result is overwritten.

Behaviour:
- Reset (asynchronous): state IDLE, ramp_reset = 1, busy = 0, result = 0, status = 00, result_valid = 0, overrun = 0, counter = 0, synchronizer flops = 1.
- comp passes through a SYNC_STAGES-flop synchronizer to give comp_s. comp_s equals comp delayed SYNC_STAGES cycles; no other logic samples comp directly.
- IDLE: ramp_reset = 1. start = 1 goes to SETTLE on the next edge and loads the settle counter with SETTLE_CYCLES-1.
- SETTLE: ramp_reset = 1 and the settle counter decrements. When it reaches 0:
  - if comp_s = 1, go to RAMP and clear the counter to 0;
  - if comp_s = 0, capture result = 0 with status UNDERFLOW, then go to NEXT.
- RAMP: ramp_reset = 0. The counter equals n in the n-th RAMP cycle (first cycle is n = 0).
  - Capture the first cycle where comp_s = 0: result = n, status OK.
  - If comp is sampled low at the edge ending RAMP cycle m, then result = m + SYNC_STAGES.
  - If n reaches MAX_COUNT with comp_s still 1, capture result = MAX_COUNT with status OVERFLOW.
  - If comp_s = 0 and n = MAX_COUNT occur in the same cycle, status is OK.
- NEXT (transient, 1 cycle): ramp_reset = 1. If continuous = 1, go to SETTLE; otherwise go to IDLE.
- Capture rules:
  - result and status register on the edge ending the capture cycle; result_valid = 1 from the following cycle.
  - result_valid holds until a cycle with result_valid & result_ready, then clears on the next edge.
  - If a capture occurs while result_valid = 1 and result_ready = 0: result and status are overwritten, result_valid stays 1, and overrun pulses for 1 cycle.
  - If a capture coincides with an acceptance: the new value loads, result_valid stays 1, and there is no overrun.
- abort has priority over every transition:
  - next state IDLE, ramp_reset = 1, counters cleared;
  - any pending valid result remains valid.
- start while busy is ignored. start and abort asserted together in IDLE: abort wins and the block stays in IDLE.
- The counter saturates at MAX_COUNT and never wraps.
- Conversion period in continuous mode = SETTLE_CYCLES + RAMP cycles + 1.

Decomposition:
- Package ramp_adc_pkg holds:
  - state enum {IDLE, SETTLE, RAMP, NEXT};
  - status constants ST_OK = 2'b00, ST_OVF = 2'b01, ST_UNF = 2'b10.
- One sub-module, comp_sync:
  - parameter SYNC_STAGES;
  - ports clk, rst, d_async, q;
  - resets to 1.

Test Plan:
1. Single-shot, normal: start pulse; comp held 1, then driven low so it is sampled low at the edge ending RAMP cycle 10 -> result = 12, status 00, result_valid after capture, busy falls, ramp_reset high through SETTLE (4 cycles) and low only in RAMP.
2. Timeout: comp held 1 -> result = 1000, status 01, ramp_reset = 0 for exactly 1001 cycles.
3. Underflow: comp held 0 before start -> after 4 SETTLE cycles, result = 0, status 10, ramp_reset never low.
4. Continuous with consumer stalled: comp falls at RAMP cycles 5, then 7, with result_ready = 0 -> overrun pulses once, result = 9; raising result_ready clears result_valid one edge later.
5. abort in RAMP cycle 20 -> IDLE next cycle, ramp_reset = 1, no new result_valid; a following start converts normally.
6. rst asserted mid-RAMP, asynchronously between edges -> all outputs at reset values immediately, ramp_reset = 1; start after release converts correctly.

Source files
------------

// File: rtl/ramp_adc_ctrl_pkg.sv
// Shared types and constants for the single-slope ramp ADC sequencer.
// The state encoding and status codes are visible to the host side as well.
package ramp_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RAMP   = 2'd2,
        NEXT   = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_OVF = 2'b01;
    localparam logic [1:0] ST_UNF = 2'b10;

    // A ramp that ends with the comparator still high can only have timed out.
    function automatic logic [1:0] ramp_status(input logic comp_high);
        logic [1:0] st;
        if (comp_high) begin
            st = ST_OVF;
        end else begin
            st = ST_OK;
        end
        return st;
    endfunction

endpackage

// File: rtl/ramp_adc_ctrl_comp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator output.
// Resets to 1 so a freshly reset block sees "ramp below input".
module comp_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_r;

    // Shift chain: q is d_async delayed by SYNC_STAGES edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d_async};
        end
    end

    assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/ramp_adc_ctrl.sv
// Single-slope conversion sequencer: discharge, release the ramp, count until the
// synchronized comparator falls, and hand the count to the host with valid/ready.
module ramp_adc_ctrl
    import ramp_adc_pkg::*;
#(
    parameter int CNT_W         = 16,
    parameter int MAX_COUNT     = 1000,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic             comp,
    output logic             ramp_reset,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic [1:0]       status,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(MAX_COUNT);

    state_t             state_r;
    state_t             next_state_s;
    logic [SET_W-1:0]   settle_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               comp_s;
    logic               capture_s;
    logic [CNT_W-1:0]   cap_result_s;
    logic [1:0]         cap_status_s;
    logic [CNT_W-1:0]   result_r;
    logic [1:0]         status_r;
    logic               valid_r;
    logic               overrun_r;
    logic               busy_r;
    logic               ramp_reset_r;

    comp_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_comp_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (comp),
        .q       (comp_s)
    );

    // Next-state and capture decode; abort overrides every transition and suppresses capture.
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        cap_result_s = '0;
        cap_status_s = ST_OK;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = SETTLE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                SETTLE: begin
                    if (settle_r != '0) begin
                        next_state_s = SETTLE;
                    end else if (comp_s) begin
                        next_state_s = RAMP;
                    end else begin
                        next_state_s = NEXT;
                        capture_s    = 1'b1;
                        cap_result_s = '0;
                        cap_status_s = ST_UNF;
                    end
                end
                RAMP: begin
                    if (!comp_s || (cnt_r == MAX_CNT)) begin
                        next_state_s = NEXT;
                        capture_s    = 1'b1;
                        cap_result_s = cnt_r;
                        cap_status_s = ramp_status(comp_s);
                    end else begin
                        next_state_s = RAMP;
                    end
                end
                NEXT: begin
                    if (continuous) begin
                        next_state_s = SETTLE;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, counters, registered outputs and the result channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            settle_r     <= '0;
            cnt_r        <= '0;
            busy_r       <= 1'b0;
            ramp_reset_r <= 1'b1;
            result_r     <= '0;
            status_r     <= ST_OK;
            valid_r      <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            busy_r       <= (next_state_s != IDLE);
            ramp_reset_r <= (next_state_s != RAMP);

            if (next_state_s != SETTLE) begin
                settle_r <= '0;
            end else if (state_r != SETTLE) begin
                settle_r <= SETTLE_LOAD;
            end else begin
                settle_r <= settle_r - SET_W'(1);
            end

            // Counter runs only while staying in RAMP and never passes MAX_COUNT.
            if ((state_r == RAMP) && (next_state_s == RAMP) && (cnt_r != MAX_CNT)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else if ((state_r == RAMP) && (next_state_s == RAMP)) begin
                cnt_r <= cnt_r;
            end else begin
                cnt_r <= '0;
            end

            if (capture_s) begin
                result_r  <= cap_result_s;
                status_r  <= cap_status_s;
                valid_r   <= 1'b1;
                overrun_r <= valid_r & ~result_ready;
            end else begin
                overrun_r <= 1'b0;
                if (valid_r && result_ready) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end
        end
    end

    assign ramp_reset   = ramp_reset_r;
    assign busy         = busy_r;
    assign result       = result_r;
    assign status       = status_r;
    assign result_valid = valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_ramp_adc_ctrl.sv
// Scoreboard bench for ramp_adc_ctrl: expected results are queued when the
// comparator stimulus is applied and checked when the DUT reports a capture.
module tb_ramp_adc_ctrl;
    import ramp_adc_pkg::*;

    localparam int CNT_W         = 16;
    localparam int MAX_COUNT     = 1000;
    localparam int SETTLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;

    typedef struct packed {
        logic [CNT_W-1:0] res;
        logic [1:0]       st;
    } exp_t;

    logic             clk          = 1'b0;
    logic             rst          = 1'b0;
    logic             start        = 1'b0;
    logic             continuous   = 1'b0;
    logic             abort        = 1'b0;
    logic             comp         = 1'b1;
    logic             result_ready = 1'b0;
    logic             ramp_reset;
    logic             busy;
    logic [CNT_W-1:0] result;
    logic [1:0]       status;
    logic             result_valid;
    logic             overrun;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   low_cnt     = 0;
    int   ovr_cnt     = 0;

    ramp_adc_ctrl #(
        .CNT_W         (CNT_W),
        .MAX_COUNT     (MAX_COUNT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .comp         (comp),
        .ramp_reset   (ramp_reset),
        .busy         (busy),
        .result       (result),
        .status       (status),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Running tallies of ramp-released cycles and overrun pulses.
    always @(negedge clk) begin
        if (!ramp_reset) low_cnt <= low_cnt + 1;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ramp(input string name, input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            n++;
            if (!ramp_reset) break;
        end
        vectors++;
        if (ramp_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ramp_start: ramp_reset=%b after %0d cycles, required 0", name, ramp_reset, n);
        end
    endtask

    task automatic wait_capture(input string name, input int budget);
        logic prev;
        logic got;
        exp_t e;
        prev = result_valid;
        got  = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if ((result_valid && !prev) || overrun) begin
                got = 1'b1;
                break;
            end
            prev = result_valid;
        end
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL %s capture_timeout: no capture within %0d cycles, required one", name, budget);
        end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s scoreboard: got result %0d with empty queue, required none", name, result);
        end else begin
            e = exp_q.pop_front();
            if (result !== e.res) begin
                miscompares++;
                $display("FAIL %s result: got %0d, required %0d", name, result, e.res);
            end
            vectors++;
            if (status !== e.st) begin
                miscompares++;
                $display("FAIL %s status: got %b, required %b", name, status, e.st);
            end
        end
    endtask

    task automatic accept_result(input string name);
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            tick();
        end
        vectors++;
        if ({busy, result_valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s pre_accept: busy,valid=%b, required 01", name, {busy, result_valid});
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept: result_valid=%b, required 0", name, result_valid);
        end
    endtask

    task automatic check_reset_values(input string name);
        vectors++;
        if ({ramp_reset, busy, result_valid, overrun, status, result} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0}) begin
            miscompares++;
            $display("FAIL %s reset_values: rr=%b busy=%b valid=%b ovr=%b st=%b res=%0d, required 1 0 0 0 00 0",
                     name, ramp_reset, busy, result_valid, overrun, status, result);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        check_reset_values("reset");
        tick();
        #2 rst = 1'b0;
        advance(3);
        check_reset_values("post_reset_idle");
    endtask

    task automatic test_single;
        int n;
        int base;
        comp = 1'b1;
        pulse_start();
        vectors++;
        if ({busy, ramp_reset} !== 2'b11) begin
            miscompares++;
            $display("FAIL single settle_out: busy,rr=%b, required 11", {busy, ramp_reset});
        end
        wait_ramp("single", 20, n);
        vectors++;
        if (n !== SETTLE_CYCLES) begin
            miscompares++;
            $display("FAIL single settle_len: got %0d, required %0d", n, SETTLE_CYCLES);
        end
        base = low_cnt;
        advance(10);
        comp = 1'b0;
        exp_q.push_back('{res: 16'd12, st: ST_OK});
        wait_capture("single", 30);
        comp = 1'b1;
        vectors++;
        if (low_cnt - base !== 13) begin
            miscompares++;
            $display("FAIL single ramp_len: got %0d, required 13", low_cnt - base);
        end
        accept_result("single");
    endtask

    task automatic test_timeout;
        int n;
        int base;
        comp = 1'b1;
        pulse_start();
        wait_ramp("timeout", 20, n);
        base = low_cnt;
        exp_q.push_back('{res: 16'd1000, st: ST_OVF});
        wait_capture("timeout", 1100);
        vectors++;
        if (low_cnt - base !== MAX_COUNT + 1) begin
            miscompares++;
            $display("FAIL timeout ramp_len: got %0d, required %0d", low_cnt - base, MAX_COUNT + 1);
        end
        accept_result("timeout");
    endtask

    task automatic test_underflow;
        int base;
        comp = 1'b0;
        advance(3);
        base = low_cnt;
        exp_q.push_back('{res: 16'd0, st: ST_UNF});
        pulse_start();
        wait_capture("underflow", 20);
        comp = 1'b1;
        vectors++;
        if (low_cnt - base !== 0) begin
            miscompares++;
            $display("FAIL underflow ramp_len: got %0d, required 0", low_cnt - base);
        end
        accept_result("underflow");
    endtask

    task automatic test_continuous;
        int n;
        int base_ovr;
        continuous   = 1'b1;
        result_ready = 1'b0;
        base_ovr     = ovr_cnt;
        pulse_start();
        wait_ramp("cont1", 20, n);
        advance(5);
        comp = 1'b0;
        exp_q.push_back('{res: 16'd7, st: ST_OK});
        wait_capture("cont1", 30);
        comp = 1'b1;
        wait_ramp("cont2", 20, n);
        advance(7);
        comp = 1'b0;
        exp_q.push_back('{res: 16'd9, st: ST_OK});
        wait_capture("cont2", 30);
        continuous = 1'b0;
        comp       = 1'b1;
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL cont overrun_pulse: got %b, required 1", overrun);
        end
        tick();
        vectors++;
        if ({overrun, result_valid} !== 2'b01 || ovr_cnt - base_ovr !== 1) begin
            miscompares++;
            $display("FAIL cont overrun_once: ovr=%b valid=%b pulses=%0d, required 0 1 1",
                     overrun, result_valid, ovr_cnt - base_ovr);
        end
        accept_result("cont");
    endtask

    task automatic test_abort;
        int n;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if ({busy, ramp_reset} !== 2'b01) begin
            miscompares++;
            $display("FAIL abort start_abort_idle: busy,rr=%b, required 01", {busy, ramp_reset});
        end
        pulse_start();
        wait_ramp("abort", 20, n);
        advance(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, ramp_reset, result_valid} !== 3'b010) begin
            miscompares++;
            $display("FAIL abort to_idle: busy,rr,valid=%b, required 010", {busy, ramp_reset, result_valid});
        end
        advance(3);
        vectors++;
        if (result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort no_result: result_valid=%b, required 0", result_valid);
        end
        pulse_start();
        wait_ramp("abort_after", 20, n);
        advance(3);
        comp = 1'b0;
        exp_q.push_back('{res: 16'd5, st: ST_OK});
        wait_capture("abort_after", 30);
        comp = 1'b1;
        accept_result("abort_after");
    endtask

    task automatic test_async_reset;
        int n;
        pulse_start();
        wait_ramp("areset", 20, n);
        advance(5);
        #2 rst = 1'b1;
        #1;
        check_reset_values("areset_mid_ramp");
        #2 rst = 1'b0;
        tick();
        check_reset_values("areset_release");
        pulse_start();
        wait_ramp("areset_after", 20, n);
        advance(8);
        comp = 1'b0;
        exp_q.push_back('{res: 16'd10, st: ST_OK});
        wait_capture("areset_after", 30);
        comp = 1'b1;
        accept_result("areset_after");
    endtask

    initial begin
        test_reset();
        test_single();
        test_timeout();
        test_underflow();
        test_continuous();
        test_abort();
        test_async_reset();
        vectors++;
        if (exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
